// File: rtl/finv_arbiter.sv
// finv_arbiter: round-robin sharing of one fixed-latency, fully pipelined
// reciprocal unit among NREQ requesters. A tag pipe follows each operand
// through the unit so the result is routed back to its originator.

// Per-requester sticky exception flags.
module finv_arbiter_lane (
    input  logic clk,
    input  logic rstn,
    input  logic rsp_vld,
    input  logic rsp_ovf,
    input  logic rsp_udf,
    input  logic clr,
    output logic sticky_ovf,
    output logic sticky_udf
);
    logic ovf_d, ovf_q, udf_d, udf_q;

    // Clear first, then OR in the new flags so a coinciding set wins.
    always_comb begin
        ovf_d = (ovf_q & ~clr) | (rsp_vld & rsp_ovf);
        udf_d = (udf_q & ~clr) | (rsp_vld & rsp_udf);
    end

    // Flag registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign sticky_ovf = ovf_q;
    assign sticky_udf = udf_q;
endmodule

module finv_arbiter #(
    parameter int NREQ    = 2,
    parameter int LATENCY = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [32*NREQ-1:0]           req_src,
    output logic [NREQ-1:0]              req_ready,
    output logic [NREQ-1:0]              resp_valid,
    output logic [31:0]                  resp_dest,
    output logic                         resp_ovf,
    output logic                         resp_udf,
    output logic [NREQ-1:0]              sticky_ovf,
    output logic [NREQ-1:0]              sticky_udf,
    input  logic [NREQ-1:0]              sticky_clr,
    output logic [$clog2(LATENCY+2)-1:0] inflight,
    output logic [31:0]                  finv_src,
    input  logic [31:0]                  finv_dest,
    input  logic                         finv_ovf,
    input  logic                         finv_udf
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(LATENCY + 2);
    localparam logic [CW-1:0] INFL_MAX = CW'(LATENCY + 1);

    logic [PW-1:0]            rr_ptr_d, rr_ptr_q;
    logic [PW-1:0]            gnt_idx, cand;
    logic                     hs;
    logic [31:0]              finv_src_d, finv_src_q;
    // Stage 0 aligns with finv_src; stage LATENCY aligns with a stable finv_dest.
    logic [LATENCY:0]         vld_pipe_d, vld_pipe_q;
    logic [LATENCY:0][PW-1:0] tag_pipe_d, tag_pipe_q;
    logic [NREQ-1:0]          resp_valid_d, resp_valid_q;
    logic [31:0]              resp_dest_d, resp_dest_q;
    logic                     resp_ovf_d, resp_ovf_q, resp_udf_d, resp_udf_q;
    logic [CW-1:0]            inflight_d, inflight_q;

    // Round-robin grant: first valid requester at or after rr_ptr.
    always_comb begin
        req_ready = '0;
        gnt_idx   = '0;
        hs        = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(rr_ptr_q) + k) % NREQ);
            if (!hs && req_valid[cand]) begin
                hs             = 1'b1;
                gnt_idx        = cand;
                req_ready[cand] = 1'b1;
            end
        end
    end

    // Issue side: pointer advance, operand register, tag pipe shift.
    always_comb begin
        rr_ptr_d   = hs ? PW'((int'(gnt_idx) + 1) % NREQ) : rr_ptr_q;
        finv_src_d = finv_src_q;
        for (int k = 0; k < NREQ; k++) begin
            if (hs && gnt_idx == PW'(k)) finv_src_d = req_src[32*k +: 32];
        end
        vld_pipe_d = {vld_pipe_q[LATENCY-1:0], hs};
        tag_pipe_d = {tag_pipe_q[LATENCY-1:0], gnt_idx};
    end

    // Response capture: only tagged finv outputs are taken.
    always_comb begin
        resp_valid_d = '0;
        resp_dest_d  = resp_dest_q;
        resp_ovf_d   = resp_ovf_q;
        resp_udf_d   = resp_udf_q;
        if (vld_pipe_q[LATENCY]) begin
            resp_valid_d[tag_pipe_q[LATENCY]] = 1'b1;
            resp_dest_d = finv_dest;
            resp_ovf_d  = finv_ovf;
            resp_udf_d  = finv_udf;
        end
    end

    // In-flight count; simultaneous issue and return cancel out.
    always_comb begin
        inflight_d = inflight_q;
        if (hs && resp_valid_q == '0 && inflight_q != INFL_MAX)
            inflight_d = inflight_q + 1'b1;
        else if (!hs && resp_valid_q != '0 && inflight_q != '0)
            inflight_d = inflight_q - 1'b1;
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr_q     <= '0;
            finv_src_q   <= '0;
            vld_pipe_q   <= '0;
            tag_pipe_q   <= '0;
            resp_valid_q <= '0;
            resp_dest_q  <= '0;
            resp_ovf_q   <= 1'b0;
            resp_udf_q   <= 1'b0;
            inflight_q   <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            finv_src_q   <= finv_src_d;
            vld_pipe_q   <= vld_pipe_d;
            tag_pipe_q   <= tag_pipe_d;
            resp_valid_q <= resp_valid_d;
            resp_dest_q  <= resp_dest_d;
            resp_ovf_q   <= resp_ovf_d;
            resp_udf_q   <= resp_udf_d;
            inflight_q   <= inflight_d;
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        finv_arbiter_lane u_lane (
            .clk        (clk),
            .rstn       (rstn),
            .rsp_vld    (resp_valid_q[i]),
            .rsp_ovf    (resp_ovf_q),
            .rsp_udf    (resp_udf_q),
            .clr        (sticky_clr[i]),
            .sticky_ovf (sticky_ovf[i]),
            .sticky_udf (sticky_udf[i])
        );
    end

    assign resp_valid = resp_valid_q;
    assign resp_dest  = resp_dest_q;
    assign resp_ovf   = resp_ovf_q;
    assign resp_udf   = resp_udf_q;
    assign inflight   = inflight_q;
    assign finv_src   = finv_src_q;
endmodule
